// File: rtl/mdio_controlador_pkg.sv
// Shared constants, frame field positions and FSM encoding for the MDIO master.
package mdio_controlador_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int ST_MSB   = 31;
    localparam int OP_MSB   = 29;
    localparam int PHY_MSB  = 27;
    localparam int REG_MSB  = 22;
    localparam int TA_MSB   = 17;
    localparam int DATA_MSB = 15;

    localparam int FRAME_LEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        FRAME    = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/mdio_controlador_if.sv
// Host request/response signals plus the serial MDIO pins of the management master.
interface mdio_controlador_if;

    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        MDIO_DONE;
    logic        BUSY;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA, MDIO_DONE, BUSY
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, MDIO_DONE, BUSY
    );

endinterface

// File: rtl/mdio_controlador_mdc_gen.sv
// MDC generator: low half then high half per bit, with strobes at bit start and mid-bit.
module mdio_controlador_mdc_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic bit_start,
    output logic sample
);

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    logic [7:0] div_cnt;
    logic       running;
    logic       tick;

    // The first tick after enable always opens a bit; afterwards MDC level selects the edge.
    assign tick      = en && (div_cnt == 8'd0);
    assign bit_start = tick && (!running || mdc);
    assign sample    = tick && running && !mdc;

    // Half-period down-counter and MDC level; everything parks low while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            running <= 1'b0;
            mdc     <= 1'b0;
        end else if (!en) begin
            div_cnt <= 8'd0;
            running <= 1'b0;
            mdc     <= 1'b0;
        end else if (tick) begin
            running <= 1'b1;
            mdc     <= sample;
            div_cnt <= DIV_M1;
        end else begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/mdio_controlador.sv
// Clause-22 MDIO master: preamble, 32-bit frame, read turnaround release and data capture.
module mdio_controlador
    import mdio_controlador_pkg::*;
#(
    parameter int DIV     = 1,
    parameter int PRE_LEN = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    mdio_controlador_if.master  bus
);

    localparam logic [5:0] PRE_CNT   = 6'(PRE_LEN);
    localparam logic [5:0] FRAME_CNT = 6'(FRAME_LEN);
    localparam logic [5:0] TA_CNT    = 6'(TA_MSB + 1);
    localparam logic [5:0] DATA_CNT  = 6'(DATA_MSB);

    state_t      state, state_nxt;
    logic [5:0]  bit_cnt, bit_cnt_nxt;
    logic [31:0] shreg, shreg_nxt;
    logic        is_read, is_read_nxt;
    logic        out_r, out_nxt;
    logic        oe_r, oe_nxt;
    logic        done_r, done_nxt;
    logic        busy_r, busy_nxt;
    logic [15:0] rd_r, rd_nxt;
    logic        mdc_en, bit_start, sample, mdc;
    logic        tristate;

    assign mdc_en = (state == PREAMBLE) || (state == FRAME);

    mdio_controlador_mdc_gen #(.DIV(DIV)) u_mdc_gen (
        .clk       (CLK),
        .rst_n     (RESET),
        .en        (mdc_en),
        .mdc       (mdc),
        .bit_start (bit_start),
        .sample    (sample)
    );

    // bit_cnt still holds the index+1 of the bit about to start; TA and data of a read are released.
    assign tristate = is_read && (bit_cnt <= TA_CNT);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        is_read_nxt = is_read;
        out_nxt     = out_r;
        oe_nxt      = oe_r;
        done_nxt    = 1'b0;
        busy_nxt    = busy_r;
        rd_nxt      = rd_r;
        case (state)
            IDLE: begin
                out_nxt  = 1'b0;
                oe_nxt   = 1'b0;
                busy_nxt = 1'b0;
                if (bus.MDIO_START) begin
                    shreg_nxt   = bus.T_DATA;
                    is_read_nxt = (bus.T_DATA[OP_MSB -: 2] == OP_READ);
                    busy_nxt    = 1'b1;
                    if (PRE_LEN == 0) begin
                        state_nxt   = FRAME;
                        bit_cnt_nxt = FRAME_CNT;
                    end else begin
                        state_nxt   = PREAMBLE;
                        bit_cnt_nxt = PRE_CNT;
                    end
                end
            end
            PREAMBLE: begin
                if (bit_start) begin
                    if (bit_cnt != 6'd0) begin
                        out_nxt     = 1'b1;
                        oe_nxt      = 1'b1;
                        bit_cnt_nxt = bit_cnt - 6'd1;
                    end else begin
                        state_nxt   = FRAME;
                        out_nxt     = shreg[ST_MSB];
                        oe_nxt      = 1'b1;
                        shreg_nxt   = {shreg[30:0], 1'b0};
                        bit_cnt_nxt = FRAME_CNT - 6'd1;
                    end
                end
            end
            FRAME: begin
                if (bit_start) begin
                    if (bit_cnt != 6'd0) begin
                        out_nxt     = shreg[ST_MSB] && !tristate;
                        oe_nxt      = !tristate;
                        shreg_nxt   = {shreg[30:0], 1'b0};
                        bit_cnt_nxt = bit_cnt - 6'd1;
                    end else begin
                        state_nxt = DONE;
                        out_nxt   = 1'b0;
                        oe_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                if (sample && is_read && (bit_cnt <= DATA_CNT)) begin
                    rd_nxt = {rd_r[14:0], bus.MDIO_IN};
                end
            end
            DONE: begin
                state_nxt = IDLE;
                out_nxt   = 1'b0;
                oe_nxt    = 1'b0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            bit_cnt <= 6'd0;
            shreg   <= 32'h0;
            is_read <= 1'b0;
            out_r   <= 1'b0;
            oe_r    <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            rd_r    <= 16'h0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            is_read <= is_read_nxt;
            out_r   <= out_nxt;
            oe_r    <= oe_nxt;
            done_r  <= done_nxt;
            busy_r  <= busy_nxt;
            rd_r    <= rd_nxt;
        end
    end

    assign bus.MDC       = mdc;
    assign bus.MDIO_OUT  = out_r;
    assign bus.MDIO_OE   = oe_r;
    assign bus.RD_DATA   = rd_r;
    assign bus.MDIO_DONE = done_r;
    assign bus.BUSY      = busy_r;

endmodule

// File: doc/mdio_controlador.md
Name: mdio_controlador

Overview:
- MDIO station-management master; the initiator end of the link that mdio_receptor serves.
- Generates MDC from the system clock, serializes an optional preamble plus a 32-bit clause-22 frame onto MDIO_OUT/MDIO_OE, and releases the line for the turnaround and data fields of reads.
- Captures read data from MDIO_IN and pulses completion.
- Sits between the host register interface and the PHY-side mdio_receptor.

Parameters:
- DIV, 1: MDC half-period in CLK cycles (bit period = 2*DIV CLK cycles); legal 1..255.
- PRE_LEN, 32: number of preamble '1' bits sent before ST; legal 0..32.

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- MDIO_START  input  1  transaction request; sampled only in IDLE.
- T_DATA  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHY addr, [22:18] REG addr, [17:16] TA, [15:0] data.
- MDIO_IN  input  1  serial data from PHY during read turnaround/data.
- MDC  output  1  management clock.
- MDIO_OUT  output  1  serial data to PHY.
- MDIO_OE  output  1  1 = controller drives MDIO.
- RD_DATA  output  16  last read result.
- MDIO_DONE  output  1  one-cycle completion pulse.
- BUSY  output  1  high from acceptance until MDIO_DONE inclusive.

Behaviour:
- All outputs registered. While RESET=0: MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0, MDIO_DONE=0, BUSY=0, state=IDLE. This takes effect immediately, including mid-transaction; the aborted frame is discarded with no DONE.
- States:
  - IDLE -> PREAMBLE on MDIO_START=1, or -> FRAME if PRE_LEN=0.
  - PREAMBLE -> FRAME after PRE_LEN bits.
  - FRAME -> DONE after 32 bits.
  - DONE -> IDLE unconditionally after 1 cycle.
- Acceptance: MDIO_START=1 at CLK edge k in IDLE.
  - T_DATA is latched into a shift register at edge k; later T_DATA changes are ignored.
  - BUSY rises at k.
  - MDIO_START outside IDLE is ignored (no queueing).
- Bit timing: each bit lasts 2*DIV cycles.
  - MDC=0 for the first DIV cycles and 1 for the last DIV cycles.
  - MDIO_OUT/MDIO_OE update on the same edge that drives MDC 1->0 (bit start), so the receiver samples mid-bit on MDC rising.
  - The first bit starts at edge k+1.
  - MDC stays 0 in IDLE and DONE.
- Preamble: MDIO_OUT=1, MDIO_OE=1.
- Frame is sent MSB first (bit 31 first).
- Write (OP != 2'b10; OP 00/11 treated as write): all 32 bits driven, MDIO_OE=1 throughout.
- Read (OP == 2'b10):
  - Bits 31..18 are driven with MDIO_OE=1.
  - From the start of bit 17 (TA) through bit 0: MDIO_OE=0 and MDIO_OUT=0.
  - MDIO_IN is sampled at the CLK edge that drives MDC 0->1 for bits 15..0 and shifted into RD_DATA MSB first.
  - TA bits are not sampled.
- ST is transmitted as given; it is not validated.
- DONE: for exactly one cycle MDIO_DONE=1, MDIO_OE=0, MDIO_OUT=0, BUSY=1.
- RD_DATA:
  - Updated only by reads.
  - Final value is valid when MDIO_DONE rises.
  - Holds between reads, and holds through writes.
  - Intermediate shifting is visible during the read.
- Latency: MDIO_DONE is high in the cycle after edge k+1+(PRE_LEN+32)*2*DIV. With defaults that is edge k+129.
- Back-to-back: the next MDIO_START is accepted at the edge that leaves DONE's successor IDLE cycle, so the minimum gap is 1 IDLE cycle.
- Counters:
  - Divider counter: 8 bits.
  - Bit counter: 6 bits; it counts down and does not wrap.

Decomposition:
- mdio_pkg holds:
  - ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10.
  - Field bit positions (ST_MSB, OP_MSB, PHY_MSB, REG_MSB, TA_MSB, DATA_MSB).
  - State encoding (IDLE, PREAMBLE, FRAME, DONE).
  - FRAME_LEN=32.
- Sub-module mdio_mdc_gen (parameter DIV): generates MDC plus single-cycle strobes bit_start (MDC 1->0 / first bit) and sample (MDC 0->1); enabled by the FSM, held low when disabled.

Test Plan:
- Write, defaults: T_DATA=32'h508AABCD, MDIO_START pulse.
  - Expect 32 ones, then serial 0101_00001_00010_10_1010101111001101 with OE=1 throughout.
  - The mdio_receptor model must see ADDR=5'h02, WR_DATA=16'hABCD and a WR_STB pulse.
  - MDIO_DONE exactly 129 cycles after acceptance; RD_DATA stays 0.
- Read, defaults: T_DATA=32'h608A0000; PHY model drives 16'h1234 on bits 15..0.
  - OE=1 for 46 bits then 0 for 18.
  - RD_DATA=16'h1234 at MDIO_DONE.
  - A following write leaves RD_DATA=16'h1234.
- DIV=3, PRE_LEN=0, write 32'h5FFF0001: MDC period 6 cycles, 3 high/3 low; no preamble; MDIO_DONE at edge k+193.
- MDIO_START held high continuously: one transaction per DONE; the second starts exactly 1 IDLE cycle after MDIO_DONE; T_DATA changed mid-frame is not reflected on MDIO_OUT.
- RESET=0 asserted at bit 40 of a read: all outputs 0 asynchronously (before the next CLK edge); no MDIO_DONE; after release a new write completes normally.
- OP=2'b11 (T_DATA=32'h708A5555): treated as a write; OE=1 all bits; RD_DATA unchanged.
